// File: rtl/regfile_param_if.sv
// Bundle of the register-file write, read, external-input and debug-scan
// signals shared between the processor datapath and the display logic.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int EXT_W  = 8
);
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic [EXT_W-1:0]  ext_data;
  logic              dbg_start;
  logic              dbg_ready;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_index;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_last;
  logic              dbg_busy;

  // Datapath / probe side: drives addresses, write data and scan control.
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB, ext_data, dbg_start, dbg_ready,
    input  data_readRegA, data_readRegB,
    input  dbg_valid, dbg_index, dbg_data, dbg_last, dbg_busy
  );

  // Register file side.
  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB, ext_data, dbg_start, dbg_ready,
    output data_readRegA, data_readRegB,
    output dbg_valid, dbg_index, dbg_data, dbg_last, dbg_busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports,
// hardwired-zero register 0, a read-only external register, optional
// write-to-read bypass and a handshaked debug scan of every register.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int EXT_REG = 29,  // must be in 1..2^ADDR_W-1
  parameter int EXT_W   = 8,   // must not exceed DATA_W
  parameter int BYPASS  = 1
) (
  input logic           clock,
  input logic           ctrl_reset,
  regfile_param_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] EXT_ADDR  = ADDR_W'(EXT_REG);
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scanState_t;

  logic [DATA_W-1:0] regArray_r [NREGS];
  logic [DATA_W-1:0] extWide_s;
  logic              writeOk_s;
  logic [DATA_W-1:0] readA_s;
  logic [DATA_W-1:0] readB_s;
  logic [ADDR_W-1:0] nextIdx_s;
  logic [DATA_W-1:0] snapData_s;

  scanState_t        scanState_r;
  logic              dbgValid_r;
  logic              dbgBusy_r;
  logic              dbgLast_r;
  logic [ADDR_W-1:0] dbgIndex_r;
  logic [DATA_W-1:0] dbgData_r;

  // Registers 0 and EXT_REG never take writes.
  function automatic logic isWritable(input logic [ADDR_W-1:0] addr);
    return (addr != ZERO_ADDR) && (addr != EXT_ADDR);
  endfunction

  // Architectural value of a register given its stored word and the live
  // external input; the stored word is ignored for the two special indices.
  function automatic logic [DATA_W-1:0] selectValue(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] extVal
  );
    logic [DATA_W-1:0] value;
    if (addr == ZERO_ADDR) begin
      value = ZERO_DATA;
    end else if (addr == EXT_ADDR) begin
      value = extVal;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  assign extWide_s = DATA_W'(bus.ext_data);
  assign writeOk_s = bus.ctrl_writeEnable && isWritable(bus.ctrl_writeReg);

  // Read port A: bypass only hits writable addresses, so special registers
  // are never bypassed.
  always_comb begin
    readA_s = ZERO_DATA;
    if ((BYPASS != 32'sd0) && writeOk_s && (bus.ctrl_readRegA == bus.ctrl_writeReg)) begin
      readA_s = bus.data_writeReg;
    end else begin
      readA_s = selectValue(bus.ctrl_readRegA, regArray_r[bus.ctrl_readRegA], extWide_s);
    end
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    readB_s = ZERO_DATA;
    if ((BYPASS != 32'sd0) && writeOk_s && (bus.ctrl_readRegB == bus.ctrl_writeReg)) begin
      readB_s = bus.data_writeReg;
    end else begin
      readB_s = selectValue(bus.ctrl_readRegB, regArray_r[bus.ctrl_readRegB], extWide_s);
    end
  end

  assign bus.data_readRegA = readA_s;
  assign bus.data_readRegB = readB_s;

  // Snapshot source for the next scan beat: pre-edge stored contents, never bypassed.
  always_comb begin
    nextIdx_s  = dbgIndex_r + ONE_ADDR;
    snapData_s = selectValue(nextIdx_s, regArray_r[nextIdx_s], extWide_s);
  end

  // Register storage: reset clears everything, otherwise store writable writes.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      regArray_r <= '{default: ZERO_DATA};
    end else if (writeOk_s) begin
      regArray_r[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Debug scan FSM; every dbg output is a register so ready/start never
  // reach the outputs combinationally.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      scanState_r <= ST_IDLE;
      dbgValid_r  <= 1'b0;
      dbgBusy_r   <= 1'b0;
      dbgLast_r   <= 1'b0;
      dbgIndex_r  <= ZERO_ADDR;
      dbgData_r   <= ZERO_DATA;
    end else begin
      case (scanState_r)
        ST_IDLE: begin
          if (bus.dbg_start) begin
            scanState_r <= ST_SCAN;
            dbgValid_r  <= 1'b1;
            dbgBusy_r   <= 1'b1;
            dbgLast_r   <= 1'b0;
            dbgIndex_r  <= ZERO_ADDR;
            dbgData_r   <= ZERO_DATA;
          end
        end
        ST_SCAN: begin
          if (bus.dbg_ready) begin
            if (dbgLast_r) begin
              scanState_r <= ST_IDLE;
              dbgValid_r  <= 1'b0;
              dbgBusy_r   <= 1'b0;
              dbgLast_r   <= 1'b0;
            end else begin
              dbgIndex_r <= nextIdx_s;
              dbgData_r  <= snapData_s;
              dbgLast_r  <= (nextIdx_s == LAST_ADDR);
            end
          end
        end
        default: begin
          scanState_r <= ST_IDLE;
          dbgValid_r  <= 1'b0;
          dbgBusy_r   <= 1'b0;
          dbgLast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dbg_valid = dbgValid_r;
  assign bus.dbg_busy  = dbgBusy_r;
  assign bus.dbg_last  = dbgLast_r;
  assign bus.dbg_index = dbgIndex_r;
  assign bus.dbg_data  = dbgData_r;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a BYPASS=1 and a BYPASS=0 instance share the same
// stimulus; a register-array model is compared every cycle, plus directed
// literal expectations.
`timescale 1ns/1ps
module tb_regfile_param;
  logic clock;
  logic ctrl_reset;
  int   errors = 0;
  int   checks = 0;
  bit   modelLive = 1'b0;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .EXT_W(8)) busA ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .EXT_W(8)) busB ();

  assign busB.ctrl_writeEnable = busA.ctrl_writeEnable;
  assign busB.ctrl_writeReg    = busA.ctrl_writeReg;
  assign busB.data_writeReg    = busA.data_writeReg;
  assign busB.ctrl_readRegA    = busA.ctrl_readRegA;
  assign busB.ctrl_readRegB    = busA.ctrl_readRegB;
  assign busB.ext_data         = busA.ext_data;
  assign busB.dbg_start        = busA.dbg_start;
  assign busB.dbg_ready        = busA.dbg_ready;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .EXT_REG(29), .EXT_W(8), .BYPASS(1)) dutA (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(busA.slave));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .EXT_REG(29), .EXT_W(8), .BYPASS(0)) dutB (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(busB.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: plain register array plus scan position.
  logic [31:0] mRegs [32];
  bit          mActive = 1'b0;
  int          mIdx = 0;
  logic [31:0] mData = 32'h0;

  function automatic logic [31:0] mValue(input int a);
    if (a == 0) return 32'h0;
    if (a == 29) return {24'h0, busA.ext_data};
    return mRegs[a];
  endfunction

  function automatic logic [31:0] expRead(input int a, input bit byp);
    if (byp && busA.ctrl_writeEnable && a == int'(busA.ctrl_writeReg) && a != 0 && a != 29)
      return busA.data_writeReg;
    return mValue(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge, using pre-edge model contents.
  always @(posedge clock) begin
    if (ctrl_reset) begin
      foreach (mRegs[i]) mRegs[i] <= 32'h0;
      mActive   <= 1'b0;
      mIdx      <= 0;
      mData     <= 32'h0;
      modelLive <= 1'b1;
    end else begin
      if (mActive) begin
        if (busA.dbg_ready) begin
          if (mIdx == 31) begin
            mActive <= 1'b0;
          end else begin
            mIdx  <= mIdx + 1;
            mData <= mValue(mIdx + 1);
          end
        end
      end else if (busA.dbg_start) begin
        mActive <= 1'b1;
        mIdx    <= 0;
        mData   <= 32'h0;
      end
      if (busA.ctrl_writeEnable && busA.ctrl_writeReg != 5'd0 && busA.ctrl_writeReg != 5'd29)
        mRegs[busA.ctrl_writeReg] <= busA.data_writeReg;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (modelLive) begin
      chk("m_rdA_byp", busA.data_readRegA, expRead(int'(busA.ctrl_readRegA), 1'b1));
      chk("m_rdB_byp", busA.data_readRegB, expRead(int'(busA.ctrl_readRegB), 1'b1));
      chk("m_rdA_nobyp", busB.data_readRegA, expRead(int'(busA.ctrl_readRegA), 1'b0));
      chk("m_rdB_nobyp", busB.data_readRegB, expRead(int'(busA.ctrl_readRegB), 1'b0));
      chk("m_valid", {31'h0, busA.dbg_valid}, {31'h0, mActive});
      chk("m_busy", {31'h0, busA.dbg_busy}, {31'h0, mActive});
      chk("m_last", {31'h0, busA.dbg_last}, {31'h0, mActive && mIdx == 31});
      chk("m_valid_b", {31'h0, busB.dbg_valid}, {31'h0, mActive});
      if (mActive) begin
        chk("m_index", {27'h0, busA.dbg_index}, mIdx);
        chk("m_data", busA.dbg_data, mData);
        chk("m_data_b", busB.dbg_data, mData);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int stalls;
    bit hit;
    logic [31:0] expv;

    ctrl_reset = 1'b1;
    busA.ctrl_writeEnable = 1'b0; busA.ctrl_writeReg = 5'd0; busA.data_writeReg = 32'h0;
    busA.ctrl_readRegA = 5'd0; busA.ctrl_readRegB = 5'd0; busA.ext_data = 8'h00;
    busA.dbg_start = 1'b0; busA.dbg_ready = 1'b0;
    step(); step();
    ctrl_reset = 1'b0;
    #1;
    chk("rst_valid", {31'h0, busA.dbg_valid}, 32'h0);
    chk("rst_busy", {31'h0, busA.dbg_busy}, 32'h0);
    chk("rst_last", {31'h0, busA.dbg_last}, 32'h0);
    chk("rst_index", {27'h0, busA.dbg_index}, 32'h0);
    chk("rst_data", busA.dbg_data, 32'h0);

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) begin
      busA.ctrl_readRegA = 5'(i);
      busA.ctrl_readRegB = 5'(31 - i);
      #1;
      chk("rst_rdA", busA.data_readRegA, 32'h0);
      chk("rst_rdB", busA.data_readRegB, 32'h0);
      step();
    end

    // Register 0 ignores writes.
    busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'd0; busA.data_writeReg = 32'hDEADBEEF;
    busA.ctrl_readRegA = 5'd0;
    #1;
    chk("r0_same", busA.data_readRegA, 32'h0);
    step();
    busA.ctrl_writeEnable = 1'b0;
    #1;
    chk("r0_after", busA.data_readRegA, 32'h0);
    chk("r0_after_b", busB.data_readRegA, 32'h0);

    // Write with bypass versus without.
    busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'd5; busA.data_writeReg = 32'h12345678;
    busA.ctrl_readRegA = 5'd5; busA.ctrl_readRegB = 5'd6;
    #1;
    chk("byp1_same", busA.data_readRegA, 32'h12345678);
    chk("byp0_same", busB.data_readRegA, 32'h0);
    chk("byp1_portB", busA.data_readRegB, 32'h0);
    chk("byp0_portB", busB.data_readRegB, 32'h0);
    step();
    busA.ctrl_writeEnable = 1'b0;
    #1;
    chk("byp0_next", busB.data_readRegA, 32'h12345678);
    chk("byp1_next", busA.data_readRegA, 32'h12345678);

    // External register: live, read-only, never bypassed.
    busA.ext_data = 8'hA5; busA.ctrl_readRegA = 5'd29; busA.ctrl_readRegB = 5'd29;
    #1;
    chk("ext_A", busA.data_readRegA, 32'h000000A5);
    chk("ext_B", busA.data_readRegB, 32'h000000A5);
    chk("ext_A_b", busB.data_readRegA, 32'h000000A5);
    busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'd29; busA.data_writeReg = 32'hFFFFFFFF;
    #1;
    chk("ext_wr_same", busA.data_readRegA, 32'h000000A5);
    step();
    busA.ctrl_writeEnable = 1'b0;
    #1;
    chk("ext_wr_next", busA.data_readRegA, 32'h000000A5);
    busA.ext_data = 8'h3C;
    #1;
    chk("ext_follow_A", busA.data_readRegA, 32'h0000003C);
    chk("ext_follow_B", busB.data_readRegB, 32'h0000003C);
    step();

    // Preload reg k = k*0x11 and run a full scan with ready held high.
    for (int k = 1; k < 32; k++) begin
      if (k != 29) begin
        busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'(k); busA.data_writeReg = 32'(k) * 32'h11;
        step();
      end
    end
    busA.ctrl_writeEnable = 1'b0;
    busA.ext_data = 8'h7E; busA.dbg_ready = 1'b1; busA.dbg_start = 1'b1;
    step();
    busA.dbg_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      expv = (k == 0) ? 32'h0 : (k == 29) ? 32'h7E : 32'(k) * 32'h11;
      chk("scan_valid", {31'h0, busA.dbg_valid}, 32'h1);
      chk("scan_index", {27'h0, busA.dbg_index}, k);
      chk("scan_data", busA.dbg_data, expv);
      chk("scan_last", {31'h0, busA.dbg_last}, (k == 31) ? 32'h1 : 32'h0);
      step();
    end
    chk("scan_done_busy", {31'h0, busA.dbg_busy}, 32'h0);

    // Backpressure at index 9 while reg 9 and reg 10 are overwritten.
    busA.dbg_start = 1'b1;
    step();
    busA.dbg_start = 1'b0;
    n = 0; stalls = 0; hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busA.dbg_valid) break;
      n++;
      busA.ctrl_writeEnable = 1'b0;
      busA.dbg_ready = 1'b1;
      if (busA.dbg_index == 5'd9) begin
        chk("stall_hold", busA.dbg_data, 32'h99);
        if (stalls < 3) begin
          busA.dbg_ready = 1'b0;
          if (stalls == 0) begin
            busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'd9; busA.data_writeReg = 32'hCAFE;
          end else if (stalls == 1) begin
            busA.ctrl_writeEnable = 1'b1; busA.ctrl_writeReg = 5'd10; busA.data_writeReg = 32'hBEEF;
          end
          stalls++;
        end
      end
      if (busA.dbg_index == 5'd10 && !hit) begin
        hit = 1'b1;
        chk("beat10_new", busA.dbg_data, 32'hBEEF);
      end
      step();
    end
    busA.ctrl_writeEnable = 1'b0; busA.dbg_ready = 1'b1;
    chk("stall_len", n, 32'd35);
    chk("stall_ended", {31'h0, busA.dbg_valid}, 32'h0);

    // Ignored restart at index 4, reset at index 12.
    busA.dbg_start = 1'b1;
    step();
    busA.dbg_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busA.dbg_index == 5'd5 && busA.dbg_valid)
        chk("restart_ignored", {27'h0, busA.dbg_index, busA.dbg_busy}, {26'h0, 5'd5, 1'b1});
      if (busA.dbg_index == 5'd12 && busA.dbg_valid) begin
        hit = 1'b1;
        busA.dbg_start = 1'b0;
        ctrl_reset = 1'b1;
        step();
        ctrl_reset = 1'b0;
        break;
      end
      busA.dbg_start = (busA.dbg_index == 5'd4);
      step();
    end
    busA.dbg_start = 1'b0;
    chk("reached_idx12", {31'h0, hit}, 32'h1);
    chk("midrst_valid", {31'h0, busA.dbg_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busA.dbg_busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      busA.ctrl_readRegA = 5'(i);
      busA.ctrl_readRegB = 5'(i);
      #1;
      chk("midrst_rd", busA.data_readRegA, (i == 29) ? 32'h7E : 32'h0);
      chk("midrst_rd_b", busB.data_readRegB, (i == 29) ? 32'h7E : 32'h0);
      step();
    end
    busA.dbg_start = 1'b1;
    step();
    busA.dbg_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("zscan_index", {27'h0, busA.dbg_index}, k);
      chk("zscan_data", busA.dbg_data, (k == 29) ? 32'h7E : 32'h0);
      step();
    end
    chk("zscan_done", {31'h0, busA.dbg_busy}, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the processor's register file. It provides a 2^ADDR_W × DATA_W register array with one write port and two combinational read ports, a hardwired-zero register 0, and one read-only external input register (the whack-a-mole random source). It adds optional same-cycle write-to-read bypass and a handshaked debug scan port that streams every register to the display/probe logic, replacing the fixed r0..r5 probes. It sits between the processor datapath and the board-level display logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2^ADDR_W
- EXT_REG, 29, index of the read-only external register; must be in 1..NREGS-1
- EXT_W, 8, width of ext_data; must be ≤ DATA_W
- BYPASS, 1, 1 = a read of the register being written this cycle returns data_writeReg; 0 = returns the stored value
- clock  in  1  system clock; all state updates on the rising edge
- ctrl_reset  in  1  reset; synchronous, active-high
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_W  write address
- data_writeReg  in  DATA_W  write data
- ctrl_readRegA / ctrl_readRegB  in  ADDR_W  read addresses
- data_readRegA / data_readRegB  out  DATA_W  read data (combinational)
- ext_data  in  EXT_W  live value of register EXT_REG
- dbg_start  in  1  request a full scan
- dbg_ready  in  1  consumer accepts the current dbg beat
- dbg_valid  out  1  dbg_index/dbg_data/dbg_last are valid
- dbg_index  out  ADDR_W  register index of the current beat
- dbg_data  out  DATA_W  snapshot of that register
- dbg_last  out  1  current beat is index NREGS-1
- dbg_busy  out  1  scan in progress

## Operation
- Storage: NREGS-2 writable registers. Register 0 always reads 0. Register EXT_REG reads {zeros, ext_data}. Writes addressed to 0 or EXT_REG are silently dropped.
- Write: when ctrl_writeEnable=1 and the address is writable, data_writeReg is stored at the clock edge.
- Read: data_readRegX = value(ctrl_readRegX), combinational. If BYPASS=1, ctrl_writeEnable=1 and ctrl_readRegX==ctrl_writeReg (writable address), the output is data_writeReg. Reads of 0 and EXT_REG are never bypassed.
- Both read ports are independent and may address the same register.
- Debug scan FSM has two states, IDLE and SCAN.
  - IDLE: dbg_valid=0, dbg_busy=0. If dbg_start=1, go to SCAN with dbg_index←0 and dbg_data←value(0).
  - SCAN: dbg_valid=1, dbg_busy=1, dbg_last=(dbg_index==NREGS-1).
    - Accept when dbg_valid & dbg_ready.
    - On accept with dbg_last=0: dbg_index←dbg_index+1, dbg_data←value(dbg_index+1).
    - On accept with dbg_last=1: go to IDLE.
    - Without accept, all dbg outputs hold. dbg_data stays stable even if the underlying register is written.
  - dbg_start is ignored in SCAN.
- Snapshot semantics: the value loaded into dbg_data is the pre-edge stored contents (never bypassed). A write on the same edge to the next-scanned register is not reflected. EXT_REG snapshots ext_data at the load edge.
- Scan does not interfere with normal reads or writes.

## Timing
- Reset (ctrl_reset=1 at an edge) has priority over writes and the scan, and aborts any scan in progress. After reset:
  - all registers = 0
  - FSM = IDLE
  - dbg_valid = dbg_busy = dbg_last = 0
  - dbg_index = 0, dbg_data = 0
- Write latency: visible on read ports the cycle after the edge. With BYPASS=1 it is also visible in the same cycle.
- Scan: dbg_start sampled at edge T → first beat valid from cycle T+1. With dbg_ready held at 1, beat k is valid in cycle T+1+k and dbg_last is high in cycle T+NREGS. The FSM is IDLE in cycle T+NREGS+1, and a new dbg_start can be sampled at the edge that ends that cycle.
- Each dbg_ready=0 cycle during SCAN extends the scan by exactly one cycle.
- No combinational path from dbg_ready or dbg_start to any dbg output.

## Test plan
- Reset/zero: after reset, read all 32 addresses → all 0. Write 0xDEADBEEF to reg 0 → reg 0 still reads 0.
- Write/read/bypass: write 0x12345678 to reg 5 while ctrl_readRegA=5.
  - BYPASS=1: A=0x12345678 in the same cycle.
  - BYPASS=0: A shows the old value 0, then 0x12345678 the next cycle.
  - Port B reading reg 6 is unaffected in both cases.
- External reg: ext_data=0xA5 → reg 29 reads 0x000000A5 on both ports. Write 0xFFFFFFFF to reg 29 → still 0x000000A5. Change ext_data to 0x3C → read follows in the same cycle.
- Full scan: preload reg k = k×0x11 (k≠0,29), ext_data=0x7E, dbg_ready=1, pulse dbg_start.
  - Expect 32 consecutive beats, index 0..31, with data matching the preload (reg 29 = 0x7E).
  - dbg_last only on index 31; dbg_busy low on the following cycle.
- Backpressure and stability: during a scan, hold dbg_ready=0 for 3 cycles at index 9 while writing 0xCAFE to reg 9 and 0xBEEF to reg 10.
  - dbg_data holds the old reg 9 value for all 3 cycles.
  - After release, the index 10 beat shows 0xBEEF.
  - Total scan length is 35 cycles.
- Reset mid-scan and ignored start: pulse dbg_start again at index 4 → no effect. Assert ctrl_reset at index 12 → next cycle dbg_valid=0, dbg_busy=0, all registers 0. A new dbg_start then yields a full scan of zeros except reg 29.
